qpsk_tx_sequencer: RTL



---
 rtl/qpsk_pkg.sv | 26 ++
 rtl/qpsk_tx_sequencer_if.sv | 25 ++
 rtl/qpsk_sample_counter.sv | 37 +++
 rtl/qpsk_tx_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// rtl/qpsk_pkg.sv - shared types and constants for the QPSK transmit sequencer
package qpsk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int SYM_W = 2;
  localparam int DEF_N = 8;
  localparam int DEF_M = 16;

  // Gray-coded dibit to carrier phase; adjacent phases differ in one bit.
  localparam logic [SYM_W-1:0] GRAY_PH_0   = 2'b00;
  localparam logic [SYM_W-1:0] GRAY_PH_90  = 2'b01;
  localparam logic [SYM_W-1:0] GRAY_PH_180 = 2'b11;
  localparam logic [SYM_W-1:0] GRAY_PH_270 = 2'b10;

  function automatic logic [1:0] gray_to_quadrant(input logic [SYM_W-1:0] sym);
    return {sym[1], sym[1] ^ sym[0]};
  endfunction

endpackage

// File: rtl/qpsk_tx_sequencer_if.sv
// rtl/qpsk_tx_sequencer_if.sv - frame handshake and datapath control bundle
interface qpsk_tx_sequencer_if #(
  parameter int IDX_W = 3
);
  logic             start;
  logic             pause;
  logic [1:0]       sipo_data;
  logic             shift_en;
  logic [1:0]       mux_sel;
  logic [IDX_W-1:0] sample_idx;
  logic             wave_valid;
  logic             sym_strobe;
  logic             busy;
  logic             done;

  modport master (
    output start, pause, sipo_data,
    input  shift_en, mux_sel, sample_idx, wave_valid, sym_strobe, busy, done
  );

  modport slave (
    input  start, pause, sipo_data,
    output shift_en, mux_sel, sample_idx, wave_valid, sym_strobe, busy, done
  );
endinterface

// File: rtl/qpsk_sample_counter.sv
// rtl/qpsk_sample_counter.sv - modulo-N counter with enable, clear and terminal-count flag
module qpsk_sample_counter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] idx,
  output logic         tc
);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] idx_q, idx_d;

  assign idx = idx_q;
  assign tc  = (idx_q == LAST);

  // Wrap at N explicitly so non-power-of-two symbol lengths work.
  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (en) begin
      idx_d = tc ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/qpsk_tx_sequencer.sv
// rtl/qpsk_tx_sequencer.sv - frame controller for the QPSK transmit datapath
module qpsk_tx_sequencer
  import qpsk_pkg::*;
#(
  parameter int SAMPLES_PER_SYMBOL = DEF_N,
  parameter int SYMBOLS_PER_FRAME  = DEF_M,
  parameter int IDX_W              = 3,
  parameter int CNT_W              = 8
) (
  input  logic               clk,
  input  logic               rst,
  qpsk_tx_sequencer_if.slave bus
);
  localparam logic [IDX_W-1:0] IDX_SHIFT_A = IDX_W'(SAMPLES_PER_SYMBOL - 3);
  localparam logic [IDX_W-1:0] IDX_SHIFT_B = IDX_W'(SAMPLES_PER_SYMBOL - 2);
  localparam logic [CNT_W-1:0] SYM_LAST    = CNT_W'(SYMBOLS_PER_FRAME);

  state_e             state_q, state_d;
  logic               fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [SYM_W-1:0]   mux_sel_q, mux_sel_d;

  logic               cnt_en, cnt_clr, cnt_tc;
  logic [IDX_W-1:0]   idx;
  logic               syms_left;

  logic shift_en, wave_valid, sym_strobe, busy, done;

  qpsk_sample_counter #(
    .N (SAMPLES_PER_SYMBOL),
    .W (IDX_W)
  ) u_sample_cnt (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .clr (cnt_clr),
    .idx (idx),
    .tc  (cnt_tc)
  );

  assign syms_left = (sym_cnt_q < SYM_LAST);

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    sym_cnt_d  = sym_cnt_q;
    mux_sel_d  = mux_sel_q;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    wave_valid = 1'b0;
    sym_strobe = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_FILL;
          fill_cnt_d = 1'b0;
          sym_cnt_d  = '0;
          cnt_clr    = 1'b1;
        end
      end

      ST_FILL: begin
        busy = 1'b1;
        if (!bus.pause) begin
          shift_en = 1'b1;
          if (fill_cnt_q) begin
            state_d = ST_LOAD;
          end else begin
            fill_cnt_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        busy = 1'b1;
        if (!bus.pause) begin
          mux_sel_d = bus.sipo_data;
          sym_cnt_d = CNT_W'(1);
          cnt_clr   = 1'b1;
          state_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        busy = 1'b1;
        if (!bus.pause) begin
          wave_valid = 1'b1;
          sym_strobe = (idx == '0);
          cnt_en     = 1'b1;
          // Prefetch the next dibit during the last samples of the current symbol.
          shift_en   = syms_left && ((idx == IDX_SHIFT_A) || (idx == IDX_SHIFT_B));
          if (cnt_tc) begin
            if (syms_left) begin
              mux_sel_d = bus.sipo_data;
              sym_cnt_d = sym_cnt_q + 1'b1;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fill_cnt_q <= 1'b0;
      sym_cnt_q  <= '0;
      mux_sel_q  <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      sym_cnt_q  <= sym_cnt_d;
      mux_sel_q  <= mux_sel_d;
    end
  end

  assign bus.shift_en   = shift_en;
  assign bus.mux_sel    = mux_sel_q;
  assign bus.sample_idx = idx;
  assign bus.wave_valid = wave_valid;
  assign bus.sym_strobe = sym_strobe;
  assign bus.busy       = busy;
  assign bus.done       = done;
endmodule
